// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory-address-register and memory signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              if_done;
    logic              dm_done;
    logic [DATA_W-1:0] rd_data;
    logic              err;
    logic              mar_write_en;
    logic              mar_read_en;
    logic [ADDR_W-1:0] mar_in;
    logic              mem_valid;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
        output if_done, dm_done, rd_data, err, mar_write_en, mar_read_en, mar_in,
               mem_valid, mem_we, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
        input  if_done, dm_done, rd_data, err, mar_write_en, mar_read_en, mar_in,
               mem_valid, mem_we, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Each transaction walks LOAD -> PRESENT -> ACCESS -> RESP with all outputs registered.
module mem_port_arbiter #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRESENT,
        ACCESS,
        RESP
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t            state_q;
    logic              owner_q;       // 1 = data port owns the current transaction
    logic              last_owner_q;  // 1 = data port owned the previous one
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        cnt_q;

    logic              if_done_q;
    logic              dm_done_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              err_q;
    logic              mar_write_en_q;
    logic              mar_read_en_q;
    logic [ADDR_W-1:0] mar_in_q;
    logic              mem_valid_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              busy_q;

    logic              grant_dm_d;

    // Data port wins when it is the only requester or when fetch owned the last transaction.
    always_comb begin
        grant_dm_d = bus.dm_req && (!bus.if_req || !last_owner_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            last_owner_q   <= 1'b1;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            cnt_q          <= '0;
            if_done_q      <= 1'b0;
            dm_done_q      <= 1'b0;
            rd_data_q      <= '0;
            err_q          <= 1'b0;
            mar_write_en_q <= 1'b0;
            mar_read_en_q  <= 1'b0;
            mar_in_q       <= '0;
            mem_valid_q    <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_wdata_q    <= '0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.if_req || bus.dm_req) begin
                        owner_q        <= grant_dm_d;
                        last_owner_q   <= grant_dm_d;
                        mar_in_q       <= grant_dm_d ? bus.dm_addr : bus.if_addr;
                        we_q           <= grant_dm_d && bus.dm_we;
                        wdata_q        <= grant_dm_d ? bus.dm_wdata : '0;
                        mar_write_en_q <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= LOAD;
                    end
                end
                LOAD: begin
                    mar_write_en_q <= 1'b0;
                    mar_read_en_q  <= 1'b1;
                    state_q        <= PRESENT;
                end
                PRESENT: begin
                    mar_read_en_q <= 1'b0;
                    mem_valid_q   <= 1'b1;
                    mem_we_q      <= we_q;
                    mem_wdata_q   <= wdata_q;
                    cnt_q         <= '0;
                    state_q       <= ACCESS;
                end
                ACCESS: begin
                    // A late mem_ready on the final allowed cycle still counts as success.
                    if (bus.mem_ready || cnt_q == LAST_CNT) begin
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        if_done_q   <= !owner_q;
                        dm_done_q   <= owner_q;
                        err_q       <= !bus.mem_ready;
                        rd_data_q   <= (bus.mem_ready && !we_q) ? bus.mem_rdata : '0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    if_done_q <= 1'b0;
                    dm_done_q <= 1'b0;
                    err_q     <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_done      = if_done_q;
    assign bus.dm_done      = dm_done_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.err          = err_q;
    assign bus.mar_write_en = mar_write_en_q;
    assign bus.mar_read_en  = mar_read_en_q;
    assign bus.mar_in       = mar_in_q;
    assign bus.mem_valid    = mem_valid_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a cycle-numbered transaction model.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Transaction model: a transaction is described by the cycle its LOAD occupies and
    // the cycle its RESP occupies; all expected outputs follow from those cycle numbers.
    bit              m_busy = 1'b0;
    int              m_load = -100;
    int              m_resp = -1;
    bit              m_owner = 1'b0;
    bit              m_last = 1'b1;
    logic [ADDR_W-1:0] m_addr = '0;
    bit              m_we = 1'b0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [DATA_W-1:0] m_rd = '0;
    bit              m_err = 1'b0;
    bit              m_rst_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Called just after a rising edge; the bench inputs still hold their pre-edge values.
    task automatic model_edge();
        int p;
        p = cyc - 1;
        m_rst_seen = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_last = 1'b1; m_rd = '0; m_err = 1'b0; m_resp = -1;
            m_rst_seen = 1'b1;
        end else if (!m_busy) begin
            if (bus.if_req || bus.dm_req) begin
                m_owner = bus.dm_req && (!bus.if_req || !m_last);
                m_last  = m_owner;
                m_addr  = m_owner ? bus.dm_addr : bus.if_addr;
                m_we    = m_owner && bus.dm_we;
                m_wdata = bus.dm_wdata;
                m_busy  = 1'b1;
                m_load  = cyc;
                m_resp  = -1;
            end
        end else if (m_resp >= 0) begin
            if (p == m_resp) m_busy = 1'b0;
        end else if (p >= m_load + 2) begin
            if (bus.mem_ready || (p - m_load - 2) == TIMEOUT - 1) begin
                m_resp = cyc;
                m_err  = !bus.mem_ready;
                m_rd   = (bus.mem_ready && !m_we) ? bus.mem_rdata : '0;
            end
        end
    endtask

    task automatic compare();
        bit e_load, e_present, e_resp, e_access;
        e_load    = m_busy && cyc == m_load;
        e_present = m_busy && cyc == m_load + 1;
        e_resp    = m_busy && cyc == m_resp;
        e_access  = m_busy && m_resp < 0 && cyc >= m_load + 2;
        chk("busy",         bus.busy,         m_busy);
        chk("mar_write_en", bus.mar_write_en, e_load);
        chk("mar_read_en",  bus.mar_read_en,  e_present);
        chk("mem_valid",    bus.mem_valid,    e_access);
        chk("if_done",      bus.if_done,      e_resp && !m_owner);
        chk("dm_done",      bus.dm_done,      e_resp && m_owner);
        chk("err",          bus.err,          e_resp && m_err);
        chk("rd_data",      bus.rd_data,      m_rd);
        if (e_access) chk("mem_we", bus.mem_we, m_we);
        if (e_access && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
        if (m_busy) chk("mar_in", bus.mar_in, m_addr);
        if (m_rst_seen) begin
            chk("rst_mar_in",    bus.mar_in,    0);
            chk("rst_mem_wdata", bus.mem_wdata, 0);
            chk("rst_mem_we",    bus.mem_we,    0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare();
    endtask

    task automatic clear_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    endtask

    initial begin
        int n_acc;
        int ready_pct;
        rst = 1'b1;
        clear_inputs();
        step(); step();
        rst = 1'b0;

        // Single fetch with immediate ready
        bus.if_req = 1'b1; bus.if_addr = 13'h0A5;
        step();
        chk("t36_mar_we", bus.mar_write_en, 1);
        chk("t36_mar_in", bus.mar_in, 32'h0A5);
        step();
        chk("t36_mar_re", bus.mar_read_en, 1);
        step();
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h1234;
        step();
        chk("t36_if_done", bus.if_done, 1);
        chk("t36_rd_data", bus.rd_data, 32'h1234);
        clear_inputs();
        step();

        // Data write
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 13'h1FFF; bus.dm_wdata = 16'hBEEF;
        step();
        chk("t38_mar_in", bus.mar_in, 32'h1FFF);
        step(); step();
        chk("t38_mem_we", bus.mem_we, 1);
        chk("t38_mem_wdata", bus.mem_wdata, 32'hBEEF);
        step();
        chk("t38_mem_we2", bus.mem_we, 1);
        chk("t38_mem_wdata2", bus.mem_wdata, 32'hBEEF);
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'hFFFF;
        step();
        chk("t38_dm_done", bus.dm_done, 1);
        chk("t38_rd_data", bus.rd_data, 0);
        clear_inputs();
        step();

        // Timeout with no ready at all
        bus.if_req = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.if_done) break;
            if (bus.mem_valid) n_acc++;
        end
        chk("t39_done", bus.if_done, 1);
        chk("t39_err", bus.err, 1);
        chk("t39_rd_data", bus.rd_data, 0);
        chk("t39_access_cycles", n_acc, TIMEOUT);
        bus.if_req = 1'b0;
        step();

        // Ready arriving on the last allowed ACCESS cycle
        bus.if_req = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.if_done) break;
            if (bus.mem_valid) begin
                n_acc++;
                if (n_acc == TIMEOUT) begin
                    bus.mem_ready = 1'b1; bus.mem_rdata = 16'h5A5A;
                end
            end
        end
        chk("t39b_done", bus.if_done, 1);
        chk("t39b_err", bus.err, 0);
        chk("t39b_rd_data", bus.rd_data, 32'h5A5A);
        clear_inputs();
        step();

        // Reset in the second ACCESS cycle, then contention from reset
        bus.if_req = 1'b1; bus.dm_req = 1'b1;
        step(); step(); step(); step();
        chk("t40_in_access", bus.mem_valid, 1);
        rst = 1'b1;
        step();
        chk("t40_busy", bus.busy, 0);
        chk("t40_mem_valid", bus.mem_valid, 0);
        chk("t40_done", {bus.if_done, bus.dm_done}, 0);
        chk("t40_rd_data", bus.rd_data, 0);
        chk("t40_mar_in", bus.mar_in, 0);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 20; i++) begin
                step();
                if (bus.if_done || bus.dm_done) break;
            end
            chk("t37_any_done", bus.if_done || bus.dm_done, 1);
            chk("t37_grant_is_data", bus.dm_done, (t == 1) ? 1 : 0);
        end
        clear_inputs();
        step(); step();

        // Input churn during PRESENT
        bus.if_req = 1'b1; bus.if_addr = 13'h0123;
        step(); step();
        bus.if_addr = 13'h1ABC; bus.if_req = 1'b0;
        step();
        chk("t41_mar_in", bus.mar_in, 32'h0123);
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h0F0F;
        step();
        chk("t41_if_done", bus.if_done, 1);
        chk("t41_rd_data", bus.rd_data, 32'h0F0F);
        clear_inputs();
        step();

        // Random traffic in four ready-density phases
        for (int i = 0; i < 4000; i++) begin
            case ((i / 1000) % 4)
                0:       ready_pct = 40;
                1:       ready_pct = 0;
                2:       ready_pct = 8;
                default: ready_pct = 25;
            endcase
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) < 10) bus.if_req = ~bus.if_req;
            if ($urandom_range(0, 99) < 10) bus.dm_req = ~bus.dm_req;
            bus.if_addr   = ADDR_W'($urandom);
            bus.dm_addr   = ADDR_W'($urandom);
            bus.dm_we     = $urandom_range(0, 1) == 1;
            bus.dm_wdata  = DATA_W'($urandom);
            bus.mem_rdata = DATA_W'($urandom);
            bus.mem_ready = $urandom_range(0, 99) < ready_pct;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 13, address width; matches the memory address register width.
REQ-002 Parameter: DATA_W, 16, memory data width.
REQ-003 Parameter: TIMEOUT, 15, maximum ACCESS cycles before a transaction is aborted (range 1..255).
REQ-004 Port: clk  in  1  clock; all state updates on the rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: if_req / if_addr  in  1 / ADDR_W  instruction-fetch request level and address (fetch is read-only).
REQ-007 Port: dm_req / dm_we / dm_addr / dm_wdata  in  1 / 1 / ADDR_W / DATA_W  data-port request, write flag, address and write data.
REQ-008 Port: if_done / dm_done  out  1  one-cycle completion pulse to the owning requester.
REQ-009 Port: rd_data  out  DATA_W  read result; valid during the done pulse.
REQ-010 Port: err  out  1  high with the done pulse when the transaction timed out.
REQ-011 Port: mar_write_en / mar_read_en  out  1  memory-address-register load and present strobes.
REQ-012 Port: mar_in  out  ADDR_W  address to load into the memory address register.
REQ-013 Port: mem_valid / mem_we / mem_wdata  out  1 / 1 / DATA_W  memory access request, direction and write data.
REQ-014 Port: mem_ready / mem_rdata  in  1 / DATA_W  memory completion and read data.
REQ-015 Port: busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, LOAD, PRESENT, ACCESS, RESP; exactly one per cycle.
REQ-017 IDLE: if either request is high, the block selects an owner, captures the owner's address, we and wdata into internal registers, and moves to LOAD; otherwise it stays in IDLE.
REQ-018 Arbitration is round-robin: with both requests high, the requester that did not own the last transaction wins; a single request wins unconditionally.
REQ-019 LOAD: mar_write_en=1 and mar_in=captured address for exactly one cycle; next state PRESENT.
REQ-020 PRESENT: mar_read_en=1 for exactly one cycle; next state ACCESS.
REQ-021 mar_write_en and mar_read_en are never high in the same cycle.
REQ-022 ACCESS: mem_valid=1, with mem_we and mem_wdata driven from the captured values; mem_we=0 for fetch transactions.
REQ-023 ACCESS: an 8-bit cycle counter starts at 0 on entry and increments each ACCESS cycle.
REQ-024 ACCESS exits to RESP on mem_ready=1, or when the counter equals TIMEOUT-1 without mem_ready; mem_ready in that same cycle takes precedence (no error).
REQ-025 On mem_ready in ACCESS, rd_data captures mem_rdata for reads; for writes, rd_data captures 0.
REQ-026 RESP: the owner's done pulse is high for exactly one cycle; err=1 only on timeout, in which case rd_data=0; next state IDLE.
REQ-027 rd_data holds its value until the next RESP.
REQ-028 Captured address, we and wdata are frozen from IDLE exit until RESP; changes on request inputs mid-transaction are ignored.
REQ-029 A requester that drops its request mid-transaction still receives its done pulse.
REQ-030 A request still high in the cycle after its done pulse starts a new arbitration in IDLE.
REQ-031 Latency: a request first seen in IDLE at cycle 0 gives LOAD at 1, PRESENT at 2 and ACCESS from 3; mem_ready at cycle k gives done at k+1 and IDLE at k+2. The minimum request-to-done latency is 4 cycles.
REQ-032 Requesters use level handshakes: each request is held until its done pulse; requests are never queued.

Reset
REQ-033 With rst=1 at a clock edge, the state goes to IDLE. All outputs (done, err, busy, mar strobes, mem_valid, mem_we) become 0, and mar_in, mem_wdata and rd_data become 0.
REQ-034 Reset sets the last owner to the data port, so the fetch port wins the first contested arbitration.
REQ-035 Reset in any state, including mid-ACCESS, aborts the transaction without a done pulse; reset overrides all other inputs.

Verification
REQ-036 Single fetch: if_req=1 with if_addr=0x0A5 and mem_ready at the first ACCESS cycle with mem_rdata=0x1234 -> mar_write_en at cycle 1 with mar_in=0x0A5, mar_read_en at cycle 2, if_done and rd_data=0x1234 at cycle 4.
REQ-037 Contention: if_req and dm_req held high from reset -> grants alternate fetch, data, fetch, and each done goes to the correct port.
REQ-038 Data write: dm_we=1, dm_addr=0x1FFF, dm_wdata=0xBEEF -> mem_we=1 and mem_wdata=0xBEEF throughout ACCESS, dm_done pulses, rd_data=0.
REQ-039 Timeout: mem_ready held at 0 with TIMEOUT=15 -> 15 ACCESS cycles, then done with err=1 and rd_data=0; with mem_ready=1 on the 15th ACCESS cycle -> err=0.
REQ-040 Reset mid-ACCESS: rst asserted in the 2nd ACCESS cycle -> IDLE and all outputs 0 next cycle with no done pulse, and the fetch port wins the following contention.
REQ-041 Input churn: if_addr changed and if_req dropped during PRESENT -> mar_in keeps the original address, and if_done still pulses.
